// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video types, screen defaults and colour constants
//
// Purpose: holds the sprite animator FSM state encoding, the default visible
// screen size and named RGB colours used by the sprite renderer.
// Ports: none (package).

package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLINK = 2'd2
  } state_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int V_VISIBLE_DEF = 480;

  localparam logic [23:0] COLOR_BLACK = 24'h000000;
  localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;
  localparam logic [23:0] COLOR_RED   = 24'hFF0000;
  localparam logic [23:0] COLOR_GREEN = 24'h00FF00;
  localparam logic [23:0] COLOR_BLUE  = 24'h0000FF;

endpackage

// File: rtl/sprite_rom.sv
// rtl/sprite_rom.sv - combinational ship sprite row masks for two animation poses
//
// Purpose: maps (pose, row) to a row mask; bit x of o_mask is set when cell x
// of that row is lit. Pose 1 differs from pose 0 only in rows 9-10 (flame).
// Ports:
//   i_pose  - animation pose (0 = ship, 1 = ship with thruster flame)
//   i_row   - sprite row 0..15 (rows beyond 10 are blank)
//   o_mask  - SPR_W-bit lit-cell mask for the row

module sprite_rom #(
  parameter int SPR_W = 11
) (
  input  logic             i_pose,
  input  logic [3:0]       i_row,
  output logic [SPR_W-1:0] o_mask
);

  function automatic logic ship_bit(input logic pose, input logic [3:0] row, input int x);
    case (row)
      4'd0:                   return (x == 5);
      4'd1:                   return (x >= 4) && (x <= 6);
      4'd2:                   return (x >= 3) && (x <= 7);
      4'd3:                   return ((x >= 2) && (x <= 4)) || ((x >= 6) && (x <= 8));
      4'd4:                   return ((x >= 1) && (x <= 3)) || ((x >= 7) && (x <= 9));
      4'd5, 4'd6, 4'd7, 4'd8: return (x <= 10);
      4'd9, 4'd10: begin
        if (pose) return ((x >= 1) && (x <= 3)) || ((x >= 7) && (x <= 9));
        else      return (x == 2) || (x == 8);
      end
      default:                return 1'b0;
    endcase
  endfunction

  always_comb begin
    o_mask = '0;
    for (int x = 0; x < SPR_W; x++) begin
      o_mask[x] = ship_bit(i_pose, i_row, x);
    end
  end

endmodule

// File: rtl/sprite_anim_render.sv
// rtl/sprite_anim_render.sv - animated victory ship sprite overlay with show/blink phases
//
// Purpose: draws a scaled two-pose ship sprite at a frame-stable position.
// SHOW animates the pose; BLINK additionally blinks the sprite until stop.
// Pixel path is a 2-stage pipeline: hit/cell registered, then colour registered.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   h_counter, v_counter - current pixel column/row of the video scan
//   pos_X, pos_Y         - requested sprite top-left, taken at frame boundaries
//   start, stop          - one-cycle animation control pulses
//   R, G, B              - registered pixel colour (2 cycles after h/v)
//   active               - registered, high while not IDLE

module sprite_anim_render import video_pkg::*; #(
  parameter int          SCALE        = 6,
  parameter int          SPR_W        = 11,
  parameter int          SPR_H        = 11,
  parameter int          STEP_FRAMES  = 15,
  parameter int          SHOW_FRAMES  = 120,
  parameter int          BLINK_FRAMES = 30,
  parameter int          H_VISIBLE    = H_VISIBLE_DEF,
  parameter int          V_VISIBLE    = V_VISIBLE_DEF,
  parameter logic [23:0] COLOR        = COLOR_WHITE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  input  logic [9:0] pos_X,
  input  logic [9:0] pos_Y,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       active
);

  // Geometry is evaluated at 12 bits so a position near 1023 plus the sprite
  // extent cannot wrap back onto the left/top of the screen.
  localparam logic [11:0] L_SCALE  = 12'(SCALE);
  localparam logic [11:0] L_SPR_PW = 12'(SPR_W * SCALE);
  localparam logic [11:0] L_SPR_PH = 12'(SPR_H * SCALE);
  localparam logic [11:0] L_HVIS   = 12'(H_VISIBLE);
  localparam logic [11:0] L_VVIS   = 12'(V_VISIBLE);
  localparam logic [11:0] L_SPR_W  = 12'(SPR_W);
  localparam logic [11:0] L_SPR_H  = 12'(SPR_H);
  localparam logic [9:0]  L_VTICK  = 10'(V_VISIBLE);

  localparam logic [15:0] L_STEP_LAST  = 16'(STEP_FRAMES - 1);
  localparam logic [15:0] L_SHOW_LAST  = 16'(SHOW_FRAMES - 1);
  localparam logic [15:0] L_BLINK_LAST = 16'(BLINK_FRAMES - 1);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

  // ---------------- frame tick ----------------
  // The counters may sit on (0, V_VISIBLE) for several clocks; only the first
  // clock of that condition is a frame tick.
  logic w_tick_cond;
  logic w_frame_tick;
  logic r_tick_cond_d;

  assign w_tick_cond  = (h_counter == 10'd0) && (v_counter == L_VTICK);
  assign w_frame_tick = w_tick_cond && !r_tick_cond_d;

  always_ff @(posedge clk) begin
    if (reset) r_tick_cond_d <= 1'b0;
    else       r_tick_cond_d <= w_tick_cond;
  end

  // ---------------- animation FSM ----------------
  state_t      r_state;
  logic        r_active;
  logic [15:0] r_frame_cnt;
  logic [15:0] r_step_cnt;
  logic [15:0] r_blink_cnt;
  logic        r_pose;
  logic        r_visible;
  logic        r_stop_pend;
  logic [9:0]  r_pos_x;
  logic [9:0]  r_pos_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_active    <= 1'b0;
      r_frame_cnt <= '0;
      r_step_cnt  <= '0;
      r_blink_cnt <= '0;
      r_pose      <= 1'b0;
      r_visible   <= 1'b1;
      r_stop_pend <= 1'b0;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
    end else begin
      // Position only moves at frame boundaries so a frame is never torn.
      if (w_frame_tick) begin
        r_pos_x <= pos_X;
        r_pos_y <= pos_Y;
      end

      case (r_state)
        ST_IDLE: begin
          // A coincident stop discards the start.
          if (start && !stop) begin
            r_state     <= ST_SHOW;
            r_active    <= 1'b1;
            r_frame_cnt <= '0;
            r_step_cnt  <= '0;
            r_blink_cnt <= '0;
            r_pose      <= 1'b0;
            r_visible   <= 1'b1;
            r_stop_pend <= 1'b0;
            r_pos_x     <= pos_X;
            r_pos_y     <= pos_Y;
          end
        end

        ST_SHOW, ST_BLINK: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_frame_tick) begin
            if (r_stop_pend || stop) begin
              r_state     <= ST_IDLE;
              r_active    <= 1'b0;
              r_stop_pend <= 1'b0;
            end else begin
              if (r_step_cnt == L_STEP_LAST) begin
                r_step_cnt <= '0;
                r_pose     <= !r_pose;
              end else begin
                r_step_cnt <= r_step_cnt + 16'd1;
              end

              if (r_state == ST_SHOW) begin
                if (r_frame_cnt == L_SHOW_LAST) begin
                  r_state     <= ST_BLINK;
                  r_visible   <= 1'b1;
                  r_blink_cnt <= '0;
                end else begin
                  r_frame_cnt <= r_frame_cnt + 16'd1;
                end
              end else begin
                if (r_blink_cnt == L_BLINK_LAST) begin
                  r_blink_cnt <= '0;
                  r_visible   <= !r_visible;
                end else begin
                  r_blink_cnt <= r_blink_cnt + 16'd1;
                end
              end
            end
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign active = r_active;

  // ---------------- pipeline stage 1: hit test and cell coordinates ----------------
  logic [11:0] w_h, w_v, w_px, w_py;
  logic [11:0] w_dx, w_dy, w_cx, w_cy;
  logic        w_hit;
  logic        r_hit;
  logic [11:0] r_cx;
  logic [11:0] r_cy;

  assign w_h  = {2'b00, h_counter};
  assign w_v  = {2'b00, v_counter};
  assign w_px = {2'b00, r_pos_x};
  assign w_py = {2'b00, r_pos_y};

  assign w_hit = (w_h >= w_px) && (w_h < w_px + L_SPR_PW) &&
                 (w_v >= w_py) && (w_v < w_py + L_SPR_PH) &&
                 (w_h < L_HVIS) && (w_v < L_VVIS);

  assign w_dx = w_h - w_px;
  assign w_dy = w_v - w_py;
  assign w_cx = w_dx / L_SCALE;
  assign w_cy = w_dy / L_SCALE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit <= 1'b0;
      r_cx  <= '0;
      r_cy  <= '0;
    end else begin
      r_hit <= w_hit;
      r_cx  <= w_cx;
      r_cy  <= w_cy;
    end
  end

  // ---------------- pipeline stage 2: pattern lookup and colour ----------------
  logic [SPR_W-1:0] w_row_mask;
  logic             w_cell_on;
  logic [23:0]      r_rgb;

  sprite_rom #(
    .SPR_W (SPR_W)
  ) u_sprite_rom (
    .i_pose (r_pose),
    .i_row  (r_cy[3:0]),
    .o_mask (w_row_mask)
  );

  // Range guard keeps the mask index in bounds even if the cell math is off-sprite.
  assign w_cell_on = r_hit && (r_cx < L_SPR_W) && (r_cy < L_SPR_H) &&
                     w_row_mask[r_cx[CW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) r_rgb <= COLOR_BLACK;
    else       r_rgb <= (w_cell_on && r_visible && r_active) ? COLOR : COLOR_BLACK;
  end

  assign R = r_rgb[23:16];
  assign G = r_rgb[15:8];
  assign B = r_rgb[7:0];

endmodule

// File: tb/tb_sprite_anim_render.sv
// tb/tb_sprite_anim_render.sv - directed plus randomized self-checking bench for sprite_anim_render

module tb_sprite_anim_render;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] h_counter, v_counter, pos_X, pos_Y;
  logic       start, stop;
  logic [7:0] R, G, B;
  logic       active;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sprite_anim_render dut (
    .clk       (clk),
    .reset     (reset),
    .h_counter (h_counter),
    .v_counter (v_counter),
    .pos_X     (pos_X),
    .pos_Y     (pos_Y),
    .start     (start),
    .stop      (stop),
    .R         (R),
    .G         (G),
    .B         (B),
    .active    (active)
  );

  // Reference model: animation described by "frames since start".
  int m_active = 0;
  int m_n      = 0;
  int m_stop   = 0;
  int m_px     = 0;
  int m_py     = 0;

  string art0 [0:10] = '{".....#.....", "....###....", "...#####...", "..###.###..",
                         ".###...###.", "###########", "###########", "###########",
                         "###########", "..#.....#..", "..#.....#.."};
  string art1 [0:10] = '{".....#.....", "....###....", "...#####...", "..###.###..",
                         ".###...###.", "###########", "###########", "###########",
                         "###########", ".###...###.", ".###...###."};

  function automatic logic [23:0] model_rgb(input int h, input int v);
    int cx, cy, pose, vis;
    byte ch;
    if (m_active == 0) return 24'h0;
    pose = (m_n / 15) % 2;
    vis  = (m_n < 120) ? 1 : ((((m_n - 120) / 30) % 2) == 0);
    if (vis == 0) return 24'h0;
    if (h < m_px || h >= m_px + 66 || v < m_py || v >= m_py + 66) return 24'h0;
    if (h >= 640 || v >= 480) return 24'h0;
    cx = (h - m_px) / 6;
    cy = (v - m_py) / 6;
    ch = (pose != 0) ? art1[cy].getc(cx) : art0[cy].getc(cx);
    return (ch == 8'h23) ? 24'hFFFFFF : 24'h0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input string tag, input int h, input int v);
    h_counter = 10'(h);
    v_counter = 10'(v);
    cyc(3);
    chk(tag, {8'h0, R, G, B}, {8'h0, model_rgb(h, v)});
    chk({tag, "_act"}, {31'h0, active}, 32'(m_active != 0));
  endtask

  task automatic frame_tick();
    h_counter = 10'd0;
    v_counter = 10'd480;
    cyc(1);
    if (m_active != 0) begin
      if (m_stop != 0) begin
        m_active = 0;
        m_stop   = 0;
      end else begin
        m_n++;
      end
    end
    m_px = int'(pos_X);
    m_py = int'(pos_Y);
    cyc(2);
    h_counter = 10'd5;
    cyc(1);
  endtask

  task automatic pulse(input logic s, input logic p);
    start = s;
    stop  = p;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    if (p && m_active != 0) m_stop = 1;
    if (s && !p && m_active == 0) begin
      m_active = 1;
      m_n      = 0;
      m_stop   = 0;
      m_px     = int'(pos_X);
      m_py     = int'(pos_Y);
    end
  endtask

  task automatic rand_checks(input string tag, input int cnt);
    int h, v;
    for (int i = 0; i < cnt; i++) begin
      h = (m_px - 3 + int'($urandom_range(0, 72))) & 1023;
      v = (m_py - 3 + int'($urandom_range(0, 72))) & 1023;
      check_pix(tag, h, v);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    h_counter = 10'd5; v_counter = 10'd0;
    pos_X = 10'd100; pos_Y = 10'd100;
    @(negedge clk);

    // Reset state
    reset = 1'b1;
    cyc(1);
    chk("rst_rgb", {8'h0, R, G, B}, 32'h0);
    chk("rst_act", {31'h0, active}, 32'h0);
    cyc(2);
    reset = 1'b0;
    check_pix("idle_pix", 100, 100);
    chk("idle_pix_const", {8'h0, R, G, B}, 32'h0);

    // start and stop together: stays idle
    pulse(1'b1, 1'b1);
    cyc(2);
    chk("start_stop_act", {31'h0, active}, 32'h0);

    // start, exact 2-cycle latency
    pulse(1'b1, 1'b0);
    chk("start_act", {31'h0, active}, 32'h1);
    check_pix("off_cell", 124, 100);
    h_counter = 10'd130;
    cyc(1);
    chk("lat1", {8'h0, R, G, B}, 32'h0);
    cyc(1);
    chk("lat2", {8'h0, R, G, B}, 32'hFFFFFF);

    rand_checks("show_rand", 12);

    // pose toggle after 15 frames
    repeat (14) frame_tick();
    check_pix("pose0", 106, 154);
    chk("pose0_const", {8'h0, R, G, B}, 32'h0);
    frame_tick();
    check_pix("pose1", 106, 154);
    chk("pose1_const", {8'h0, R, G, B}, 32'hFFFFFF);

    // position change takes effect only at a frame tick
    pos_X = 10'd200;
    check_pix("tear_old", 130, 130);
    frame_tick();
    check_pix("tear_new", 230, 130);
    pos_X = 10'd100;
    frame_tick();
    rand_checks("show_rand2", 12);

    // into BLINK: row 5 on for 30 frames, off for 30
    while (m_n < 120) frame_tick();
    for (int f = 0; f < 60; f++) begin
      check_pix("blink", 130, 130);
      chk("blink_const", {8'h0, R, G, B}, (f < 30) ? 32'hFFFFFF : 32'h0);
      frame_tick();
    end

    // stop mid-frame: output stays until the next frame tick
    pulse(1'b0, 1'b1);
    check_pix("stop_hold", 130, 130);
    chk("stop_hold_act", {31'h0, active}, 32'h1);
    frame_tick();
    check_pix("stop_done", 130, 130);
    chk("stop_done_act", {31'h0, active}, 32'h0);

    // far edge position: no wrap, fully clipped
    pos_X = 10'd1020; pos_Y = 10'd470;
    pulse(1'b1, 1'b0);
    for (int h = 1015; h < 1024; h++) check_pix("edge_h", h, 470);
    check_pix("nowrap0", 0, 470);
    check_pix("nowrap1", 5, 475);
    check_pix("nowrap2", 3, 0);

    // right-edge clipping inside the visible area
    pos_X = 10'd600; pos_Y = 10'd100;
    frame_tick();
    check_pix("clip_in", 636, 130);
    check_pix("clip_out", 650, 130);
    rand_checks("clip_rand", 16);

    // reset mid-SHOW aborts immediately
    check_pix("pre_rst", 630, 130);
    reset = 1'b1;
    m_active = 0; m_n = 0; m_stop = 0;
    cyc(1);
    chk("midrst_rgb", {8'h0, R, G, B}, 32'h0);
    chk("midrst_act", {31'h0, active}, 32'h0);
    reset = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
